rr_grant_encoder: RTL and testbench

- Round-robin arbiter for four requesters. Emits the winner as a 2-bit encoded index plus an enable.
- Sits directly upstream of the team's 2-to-4 one-hot decoder: gnt_idx drives the decoder select, gnt_en drives its enable.
- Holds a grant until the owner releases it or a hold timeout fires, then rotates priority.

---
 rtl/rr_grant_encoder_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 33 +++
 rtl/rr_grant_encoder.sv | 116 +++++++++++
 tb/tb_rr_grant_encoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_encoder_pkg.sv
// Shared definitions for the round-robin grant encoder.
//   state_t   : arbiter FSM states (IDLE, GRANT)
//   REQ_N     : number of requesters
//   IDX_W     : width of an encoded requester index
//   idx_after : index reached by stepping 'offset' places after 'base', mod REQ_N
package rr_grant_encoder_pkg;

  localparam int REQ_N = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // REQ_N is a power of two, so natural IDX_W-bit wrap gives the modulo.
  function automatic logic [IDX_W-1:0] idx_after(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search.
//   req : request vector, bit i = requester i
//   ptr : highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   idx : first requesting index in search order (ptr when none)
//   any : at least one request present
module rr_priority_pick
  import rr_grant_encoder_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      cand = idx_after(ptr, IDX_W'(k));
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for four requesters with encoded grant output.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   req     : request vector, bit i = requester i
//   done    : owner releases its grant (pulse)
//   gnt_idx : encoded index of the granted requester (held after release)
//   gnt_en  : grant valid
//   timeout : one-cycle pulse when a grant is ended by HOLD_MAX
//   busy    : high while in GRANT
// All outputs are registered. HOLD_MAX = 0 disables the timeout.
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int HOLD_W   = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_en,
  output logic             timeout,
  output logic             busy
);

  localparam logic              TIMEOUT_ON = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = TIMEOUT_ON ? HOLD_W'(HOLD_MAX - 1) : {HOLD_W{1'b1}};

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  ptr_r, ptr_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [IDX_W-1:0]  idx_s;
  logic              en_s, to_s, busy_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_any_s;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Next-state and next-output logic for the arbiter.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    hold_s  = hold_r;
    idx_s   = gnt_idx;
    en_s    = gnt_en;
    busy_s  = busy;
    to_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          idx_s   = pick_idx_s;
          en_s    = 1'b1;
          busy_s  = 1'b1;
          hold_s  = {HOLD_W{1'b0}};
          state_s = GRANT;
        end else begin
          en_s    = 1'b0;
          busy_s  = 1'b0;
        end
      end
      GRANT: begin
        // Release paths leave gnt_idx untouched and advance priority past the owner.
        if (done || !req[gnt_idx]) begin
          en_s    = 1'b0;
          busy_s  = 1'b0;
          ptr_s   = idx_after(gnt_idx, IDX_W'(1));
          state_s = IDLE;
        end else if (TIMEOUT_ON && (hold_r == HOLD_LAST)) begin
          en_s    = 1'b0;
          busy_s  = 1'b0;
          to_s    = 1'b1;
          ptr_s   = idx_after(gnt_idx, IDX_W'(1));
          state_s = IDLE;
        end else if (hold_r != {HOLD_W{1'b1}}) begin
          hold_s  = hold_r + HOLD_W'(1);
        end else begin
          // Only reachable with the timeout disabled: saturate instead of wrapping.
          hold_s  = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
        en_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= {IDX_W{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      gnt_idx <= {IDX_W{1'b0}};
      gnt_en  <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
      gnt_idx <= idx_s;
      gnt_en  <= en_s;
      timeout <= to_s;
      busy    <= busy_s;
    end
  end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Testbench for rr_grant_encoder (HOLD_MAX = 3): directed vector table,
// hand-written reset sequences and randomized traffic against a reference model.
module tb_rr_grant_encoder;

  localparam int HM = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_en, timeout, busy;

  int checks = 0;
  int passed = 0;

  // Reference model: owner index, cycles already granted, priority pointer.
  int m_busy, m_idx, m_to, m_ptr, m_held;

  typedef struct {
    logic [3:0] r;
    logic       d;
    logic [4:0] exp;  // {gnt_en, gnt_idx, timeout, busy}
    string      name;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_grant_encoder #(.HOLD_W(4), .HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .timeout (timeout),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {gnt_en, gnt_idx, timeout, busy};
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got en/idx/to/busy=%b required %b at %0t", name, act, exp, $time);
  endtask

  function automatic logic [4:0] model_out();
    return {(m_busy != 0), 2'(m_idx), (m_to != 0), (m_busy != 0)};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_to = 0; m_ptr = 0; m_held = 0;
  endtask

  task automatic model_release(input int fired);
    m_busy = 0;
    m_to   = fired;
    m_ptr  = (m_idx + 1) % 4;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_edge(input logic [3:0] r, input logic d);
    if (m_busy == 0) begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_busy == 0 && r[(m_ptr + k) % 4]) begin
          m_idx  = (m_ptr + k) % 4;
          m_busy = 1;
          m_held = 1;
        end
      end
    end else if (d || !r[m_idx]) begin
      model_release(0);
    end else if (HM != 0 && m_held >= HM) begin
      model_release(1);
    end else begin
      m_held++;
      m_to = 0;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic d, input logic en, input logic [1:0] idx,
                     input logic to, input logic bz, input string name);
    vec_t v;
    v.r = r; v.d = d; v.exp = {en, idx, to, bz}; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    model_reset();

    add(4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "rot_g0");
    add(4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "rot_r0");
    add(4'hF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, "rot_g1");
    add(4'hF, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, "rot_r1");
    add(4'hF, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "rot_g2");
    add(4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, "rot_r2");
    add(4'hF, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, "rot_g3");
    add(4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, "rot_r3");
    add(4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "rot_wrap");
    add(4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "rot_rwrap");
    add(4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "to_c1");
    add(4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "to_c2");
    add(4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "to_c3");
    add(4'h4, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, "to_fire");
    add(4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "to_regrant");
    add(4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "dw_c2");
    add(4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, "dw_c3");
    add(4'h4, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, "done_wins");
    add(4'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, "idle_noreq");
    add(4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, "idle_done");
    add(4'h2, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, "own1_grant");
    add(4'h9, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, "own1_drop");
    add(4'h9, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, "search_ptr2");
    add(4'h9, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, "rel3");
    add(4'h9, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "g0");
    add(4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "others_chg");
    add(4'h1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "hold3");
    add(4'h1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "to_idx0");

    // Reset applied with all requesters active: no grant while held.
    #1;
    check("reset_vals", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("in_reset", 5'b00000);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].d);
      check(tbl[i].name, tbl[i].exp);
    end

    // Asynchronous reset between edges in the middle of a grant.
    step(4'hF, 1'b0);
    check("pre_rst_grant", 5'b10101);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1010, 1'b0);
    check("post_rst_ptr0", 5'b10101);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    begin
      logic [3:0] r;
      logic       d;
      r = 4'h0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) < 4) r = 4'($urandom_range(0, 15));
        d = ($urandom_range(0, 4) == 0);
        step(r, d);
        check("random", model_out());
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
